// File: rtl/sram_pkg.sv
// Shared types and constants for the cartridge SRAM arbiter and its address counter.
package sram_pkg;

  localparam int ADDR_W_DEF = 21;
  localparam int DATA_W_DEF = 8;

  // {ce_n, oe_n, we_n} with every strobe deasserted
  localparam logic [2:0] STROBE_IDLE = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_SETUP  = 3'd1,
    ST_W_STROBE = 3'd2,
    ST_W_HOLD   = 3'd3,
    ST_R_SETUP  = 3'd4,
    ST_R_STROBE = 3'd5,
    ST_SNES     = 3'd6,
    ST_TURN     = 3'd7
  } state_t;

  // True while an AVR access is in flight and must not be disturbed
  function automatic logic is_access(input state_t s);
    return (s == ST_W_SETUP) || (s == ST_W_STROBE) || (s == ST_W_HOLD) ||
           (s == ST_R_SETUP) || (s == ST_R_STROBE);
  endfunction

endpackage

// File: rtl/sram_addr_counter.sv
// AVR-side SRAM address counter: load, increment, natural wrap at 2^ADDR_W.
module sram_addr_counter #(
  parameter int ADDR_W = 21
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_ld,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] r_addr;

  // A load always wins over a simultaneous increment
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
    end else if (i_ld) begin
      r_addr <= i_addr;
    end else if (i_inc) begin
      r_addr <= r_addr + ADDR_W'(1);
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/sram_arbiter.sv
// Clocked SRAM sequencer sharing one SRAM between AVR upload/readback and SNES read pass-through.
// AVR handshake: avr_req is a level held until the one-cycle avr_ack; command fields sample on acceptance.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int STROBE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              snes_mode,
  input  logic              avr_req,
  input  logic              avr_wr,
  input  logic [DATA_W-1:0] avr_wdata,
  input  logic [ADDR_W-1:0] avr_addr,
  input  logic              avr_addr_ld,
  input  logic              avr_auto_inc,
  output logic              avr_ack,
  output logic [DATA_W-1:0] avr_rdata,
  output logic              avr_busy,
  output logic [ADDR_W-1:0] avr_cur_addr,
  input  logic [ADDR_W-1:0] snes_addr,
  output logic [DATA_W-1:0] snes_data,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_din,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_dout_en,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [2:0]        dbg_state
);

  localparam logic [3:0] STRB_LAST = 4'(STROBE_CYCLES - 1);

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_strb_cnt;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_reset_q;

  logic              w_strb_last;
  logic              w_accept;
  logic              w_rd_done;
  logic              w_ack;
  logic              w_cnt_ld;
  logic              w_cnt_inc;
  logic [ADDR_W-1:0] w_cnt_addr;
  logic [2:0]        w_strobes;
  logic              w_dout_en;

  assign w_strb_last = (r_strb_cnt == STRB_LAST);
  assign w_accept    = (r_state == ST_IDLE) && !snes_mode && avr_req;
  assign w_rd_done   = (r_state == ST_R_STROBE) && w_strb_last;
  assign w_ack       = (r_state == ST_W_HOLD) || w_rd_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // snes_mode is only looked at in IDLE and SNES, so a started access always completes
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (snes_mode) begin
          w_next = ST_SNES;
        end else if (avr_req) begin
          w_next = avr_wr ? ST_W_SETUP : ST_R_SETUP;
        end
      end
      ST_W_SETUP:  w_next = ST_W_STROBE;
      ST_W_STROBE: w_next = w_strb_last ? ST_W_HOLD : ST_W_STROBE;
      ST_W_HOLD:   w_next = ST_IDLE;
      ST_R_SETUP:  w_next = ST_R_STROBE;
      ST_R_STROBE: w_next = w_strb_last ? ST_IDLE : ST_R_STROBE;
      ST_SNES:     w_next = snes_mode ? ST_SNES : ST_TURN;
      ST_TURN:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // Strobe counter runs only inside the strobe states; it is zero on entry from SETUP
  always_ff @(posedge clk) begin
    if (reset) begin
      r_strb_cnt <= '0;
    end else if (((r_state == ST_W_STROBE) || (r_state == ST_R_STROBE)) && !w_strb_last) begin
      r_strb_cnt <= r_strb_cnt + 4'd1;
    end else begin
      r_strb_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wdata <= '0;
    end else if (w_accept) begin
      r_wdata <= avr_wdata;
    end
  end

  // A single-cycle reset aborting a read keeps the last good data; a held reset clears it
  always_ff @(posedge clk) begin
    r_reset_q <= reset;
    if (reset) begin
      if (r_reset_q) begin
        r_rdata <= '0;
      end
    end else if (w_rd_done) begin
      r_rdata <= sram_din;
    end
  end

  assign w_cnt_ld  = avr_addr_ld && !is_access(r_state);
  assign w_cnt_inc = w_ack && avr_auto_inc;

  sram_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_addr_counter (
    .clk    (clk),
    .reset  (reset),
    .i_ld   (w_cnt_ld),
    .i_addr (avr_addr),
    .i_inc  (w_cnt_inc),
    .o_addr (w_cnt_addr)
  );

  always_comb begin
    w_strobes = STROBE_IDLE;
    w_dout_en = 1'b0;
    case (r_state)
      ST_W_SETUP:  begin w_strobes = 3'b011; w_dout_en = 1'b1; end
      ST_W_STROBE: begin w_strobes = 3'b010; w_dout_en = 1'b1; end
      ST_W_HOLD:   begin w_strobes = 3'b011; w_dout_en = 1'b1; end
      ST_R_SETUP:  w_strobes = 3'b001;
      ST_R_STROBE: w_strobes = 3'b001;
      ST_SNES:     w_strobes = 3'b001;
      default:     w_strobes = STROBE_IDLE;
    endcase
  end

  assign {sram_ce_n, sram_oe_n, sram_we_n} = w_strobes;
  assign sram_dout_en = w_dout_en;
  assign sram_dout    = r_wdata;
  assign sram_addr    = (r_state == ST_SNES) ? snes_addr : w_cnt_addr;
  assign snes_data    = (r_state == ST_SNES) ? sram_din : {DATA_W{1'b1}};

  // Read data bypasses the register so it is valid in the ack cycle itself
  assign avr_rdata    = w_rd_done ? sram_din : r_rdata;
  assign avr_ack      = w_ack;
  assign avr_busy     = (r_state != ST_IDLE);
  assign avr_cur_addr = w_cnt_addr;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with a behavioural SRAM on the pins.
module tb_sram_arbiter;
  import sram_pkg::*;

  localparam int AW = 21;
  localparam int DW = 8;
  localparam int SC = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          snes_mode;
  logic          avr_req;
  logic          avr_wr;
  logic [DW-1:0] avr_wdata;
  logic [AW-1:0] avr_addr;
  logic          avr_addr_ld;
  logic          avr_auto_inc;
  logic          avr_ack;
  logic [DW-1:0] avr_rdata;
  logic          avr_busy;
  logic [AW-1:0] avr_cur_addr;
  logic [AW-1:0] snes_addr;
  logic [DW-1:0] snes_data;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;
  logic          sram_dout_en;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [7:0]    mem [0:255];

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(SC)) dut (
    .clk (clk), .reset (reset), .snes_mode (snes_mode),
    .avr_req (avr_req), .avr_wr (avr_wr), .avr_wdata (avr_wdata),
    .avr_addr (avr_addr), .avr_addr_ld (avr_addr_ld), .avr_auto_inc (avr_auto_inc),
    .avr_ack (avr_ack), .avr_rdata (avr_rdata), .avr_busy (avr_busy),
    .avr_cur_addr (avr_cur_addr), .snes_addr (snes_addr), .snes_data (snes_data),
    .sram_addr (sram_addr), .sram_din (sram_din), .sram_dout (sram_dout),
    .sram_dout_en (sram_dout_en), .sram_ce_n (sram_ce_n), .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n), .dbg_state (dbg_state)
  );

  // Behavioural SRAM, decoded on the low address byte only
  assign sram_din = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 8'hEE;
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dout_en) mem[sram_addr[7:0]] <= sram_dout;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Bus contention guard: output drivers never on while the SRAM drives the pins
  always @(negedge clk) begin
    if (reset === 1'b0) check("no_contention", {31'd0, (sram_dout_en === 1'b1) && (sram_oe_n === 1'b0)}, 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_pop(input string name);
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: actual read %0h required none queued", name, avr_rdata);
    end else begin
      e = exp_q.pop_front();
      check(name, avr_rdata, e);
    end
  endtask

  task automatic load_addr(input logic [AW-1:0] a);
    avr_addr    = a;
    avr_addr_ld = 1'b1;
    step();
    avr_addr_ld = 1'b0;
    check("addr_load", avr_cur_addr, a);
  endtask

  task automatic wait_ack(output int n, output logic got);
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (avr_ack === 1'b1) got = 1'b1;
    end
  endtask

  // One access from IDLE; measures latency and strobe widths, scoreboards read data
  task automatic run_access(input string name, input logic wr, input logic [7:0] wd,
                            input logic inc, input logic [7:0] exp_rd);
    int   n, we_lo, oe_lo;
    logic got;
    if (!wr) exp_q.push_back(exp_rd);
    avr_wr = wr; avr_wdata = wd; avr_auto_inc = inc; avr_req = 1'b1;
    n = 0; we_lo = 0; oe_lo = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (sram_we_n === 1'b0) we_lo++;
      if (sram_oe_n === 1'b0) oe_lo++;
      if (avr_ack === 1'b1) got = 1'b1;
    end
    check({name, "_ack"}, got, 1);
    if (got) begin
      if (!wr) sb_pop({name, "_rdata"});
      check({name, "_lat"}, n - 1, wr ? SC + 2 : SC + 1);
      check({name, "_we_w"}, we_lo, wr ? SC : 0);
      check({name, "_oe_w"}, oe_lo, wr ? 0 : SC + 1);
    end else begin
      exp_q.delete();
    end
    step();
    avr_req = 1'b0;
    check({name, "_ack_pulse"}, avr_ack, 0);
  endtask

  typedef struct {
    logic          ld;
    logic [AW-1:0] addr;
    logic          wr;
    logic [7:0]    data;
    logic          inc;
    logic [7:0]    exp_rd;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int   n;
    logic got;
    #200000;
    $display("FAIL watchdog: actual time limit reached required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic got;

    vecs[0] = '{1'b1, 21'h000010, 1'b1, 8'hA5, 1'b1, 8'h00, 21'h000011};
    vecs[1] = '{1'b1, 21'h000010, 1'b0, 8'h00, 1'b0, 8'hA5, 21'h000010};
    vecs[2] = '{1'b1, 21'h1FFFFF, 1'b1, 8'h3C, 1'b1, 8'h00, 21'h000000};
    vecs[3] = '{1'b0, 21'h000000, 1'b1, 8'h5A, 1'b1, 8'h00, 21'h000001};
    vecs[4] = '{1'b0, 21'h000000, 1'b1, 8'h77, 1'b1, 8'h00, 21'h000002};
    vecs[5] = '{1'b1, 21'h1FFFFF, 1'b0, 8'h00, 1'b1, 8'h3C, 21'h000000};
    vecs[6] = '{1'b0, 21'h000000, 1'b0, 8'h00, 1'b1, 8'h5A, 21'h000001};
    vecs[7] = '{1'b0, 21'h000000, 1'b0, 8'h00, 1'b1, 8'h77, 21'h000002};
    vecs[8] = '{1'b1, 21'h000011, 1'b1, 8'h00, 1'b0, 8'h00, 21'h000011};
    vecs[9] = '{1'b0, 21'h000000, 1'b0, 8'h00, 1'b0, 8'h00, 21'h000011};

    reset = 1'b1; snes_mode = 1'b0; avr_req = 1'b0; avr_wr = 1'b0; avr_wdata = '0;
    avr_addr = '0; avr_addr_ld = 1'b0; avr_auto_inc = 1'b0; snes_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    check("rst_outs", {avr_ack, avr_busy, sram_dout_en}, 3'b000);
    check("rst_rdata", avr_rdata, 0);
    check("rst_cur_addr", avr_cur_addr, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_sram_dout", sram_dout, 0);
    check("rst_snes_data", snes_data, 8'hFF);
    reset = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].ld) load_addr(vecs[i].addr);
      run_access($sformatf("vec%0d", i), vecs[i].wr, vecs[i].data, vecs[i].inc, vecs[i].exp_rd);
      check($sformatf("vec%0d_cur_addr", i), avr_cur_addr, vecs[i].exp_addr);
    end

    // Back-to-back writes with avr_req held: exactly one IDLE cycle between them
    load_addr(21'h000040);
    avr_wr = 1'b1; avr_wdata = 8'h11; avr_auto_inc = 1'b1; avr_req = 1'b1;
    wait_ack(n, got);
    check("b2b_first_ack", got, 1);
    step();
    avr_wdata = 8'h22;
    @(negedge clk);
    check("b2b_gap_idle", {avr_busy, dbg_state}, {1'b0, ST_IDLE});
    @(negedge clk);
    check("b2b_second_accept", dbg_state, ST_W_SETUP);
    wait_ack(n, got);
    check("b2b_second_ack_n", n, SC + 1);
    step();
    avr_req = 1'b0;
    check("b2b_cur_addr", avr_cur_addr, 21'h000042);
    load_addr(21'h000041);
    run_access("b2b_readback", 1'b0, 8'h00, 1'b0, 8'h22);

    // snes_mode raised mid-write: write completes, one IDLE cycle, then SNES
    load_addr(21'h000030);
    avr_wr = 1'b1; avr_wdata = 8'hC3; avr_auto_inc = 1'b0; avr_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("midw_in_strobe", dbg_state, ST_W_STROBE);
    snes_mode = 1'b1;
    wait_ack(n, got);
    check("midw_ack", got, 1);
    check("midw_ack_n", n, 2);
    step();
    avr_req = 1'b0;
    @(negedge clk);
    check("midw_idle", {avr_busy, sram_ce_n, sram_oe_n, sram_we_n}, 4'b0111);
    @(negedge clk);
    check("midw_snes_state", dbg_state, ST_SNES);
    check("midw_snes_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en}, 4'b0010);
    snes_addr = 21'h000010;
    #1;
    check("snes_addr_pass", sram_addr, 21'h000010);
    check("snes_data_a5", snes_data, 8'hA5);
    snes_addr = 21'h000030;
    #1;
    check("snes_data_c3", snes_data, 8'hC3);
    @(negedge clk);
    snes_mode = 1'b0;
    @(negedge clk);
    check("turn_state", dbg_state, ST_TURN);
    check("turn_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    check("turn_snes_data", snes_data, 8'hFF);
    @(negedge clk);
    check("turn_to_idle", dbg_state, ST_IDLE);

    // snes_mode and avr_req together: SNES first, request served after TURN and IDLE
    load_addr(21'h000030);
    exp_q.push_back(8'hC3);
    avr_wr = 1'b0; avr_auto_inc = 1'b0; snes_mode = 1'b1; avr_req = 1'b1;
    got = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (avr_ack === 1'b1) got = 1'b1;
    end
    check("simul_no_ack", got, 0);
    check("simul_snes", dbg_state, ST_SNES);
    snes_mode = 1'b0;
    wait_ack(n, got);
    check("simul_ack", got, 1);
    check("simul_ack_n", n, 2 + SC + 1);
    if (got) sb_pop("simul_rdata");
    else exp_q.delete();
    step();
    avr_req = 1'b0;
    check("simul_rdata_held", avr_rdata, 8'hC3);

    // One-cycle reset during R_STROBE aborts the read and keeps the old rdata
    load_addr(21'h000010);
    avr_wr = 1'b0; avr_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rrst_in_strobe", {avr_ack, dbg_state}, {1'b0, ST_R_STROBE});
    reset = 1'b1;
    avr_req = 1'b0;
    @(negedge clk);
    check("rrst_idle", {avr_ack, avr_busy, sram_ce_n, sram_oe_n, sram_we_n}, 5'b00111);
    check("rrst_rdata_kept", avr_rdata, 8'hC3);
    reset = 1'b0;
    got = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (avr_ack === 1'b1) got = 1'b1;
    end
    check("rrst_no_ack", got, 0);
    check("rrst_rdata_still", avr_rdata, 8'hC3);

    // Held reset clears everything, including rdata
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("hrst_rdata", avr_rdata, 0);
    check("hrst_cur_addr", avr_cur_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Owns the single cartridge SRAM and shares it between the AVR (upload/readback, with an internal auto-incrementing address counter) and the SNES bus (read-only pass-through). It sits between the AVR/SNES-facing logic and the SRAM pins. It replaces ad-hoc strobe gating with a clocked sequencer that guarantees:
- address setup before every strobe;
- a minimum strobe width;
- data hold after every write;
- a dead cycle on every ownership change.

## Interface
Parameters:
- ADDR_W, 21, SRAM/SNES address width
- DATA_W, 8, data width
- STROBE_CYCLES, 2, cycles sram_we_n/sram_oe_n held low per AVR access (legal range 1..15)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- snes_mode  in  1  1 = SNES owns SRAM, 0 = AVR owns SRAM
- avr_req  in  1  level; AVR access request, held until avr_ack
- avr_wr  in  1  1 = write, 0 = read; sampled on acceptance
- avr_wdata  in  DATA_W  write data; sampled on acceptance
- avr_addr  in  ADDR_W  address to load into counter
- avr_addr_ld  in  1  load counter from avr_addr (1-cycle pulse)
- avr_auto_inc  in  1  increment counter after each completed access
- avr_ack  out  1  1-cycle pulse on access completion
- avr_rdata  out  DATA_W  last read data, held until next read completes
- avr_busy  out  1  state != IDLE
- avr_cur_addr  out  ADDR_W  current counter value
- snes_addr  in  ADDR_W  SNES bus address
- snes_data  out  DATA_W  SNES read data
- sram_addr  out  ADDR_W  SRAM address
- sram_din  in  DATA_W  SRAM data pins, input side
- sram_dout  out  DATA_W  SRAM data pins, output side
- sram_dout_en  out  1  tristate enable for sram_dout
- sram_ce_n, sram_oe_n, sram_we_n  out  1  SRAM strobes, active low

## Operation
State machine states: IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_STROBE, SNES, TURN.

IDLE:
- All strobes high; dout_en = 0.
- If snes_mode = 1, go to SNES. This takes priority over avr_req in the same cycle; the request stays pending.
- Otherwise, if avr_req = 1, latch avr_wr and avr_wdata, then go to W_SETUP (write) or R_SETUP (read).

Write sequence:
- W_SETUP (1 cycle): sram_addr = counter, sram_dout = latched data, dout_en = 1, ce_n = 0.
- W_STROBE (STROBE_CYCLES cycles): adds we_n = 0.
- W_HOLD (1 cycle): we_n = 1; ce_n = 0, address and data still driven. Then avr_ack and go to IDLE.

Read sequence:
- R_SETUP (1 cycle): ce_n = 0, oe_n = 0, dout_en = 0.
- R_STROBE (STROBE_CYCLES cycles): same outputs.
- On the last R_STROBE cycle, register sram_din into avr_rdata, pulse avr_ack and go to IDLE.

SNES state:
- ce_n = 0, oe_n = 0, we_n = 1, dout_en = 0.
- sram_addr = snes_addr, combinational.
- snes_data = sram_din, combinational.
- Outside SNES state, snes_data = all ones.
- snes_mode = 0 moves to TURN. TURN lasts 1 cycle with all strobes high, then goes to IDLE.

Address counter:
- avr_addr_ld loads the counter. It is honoured in any state except W_* and R_*; during an access it is ignored.
- On avr_ack with avr_auto_inc = 1, the counter increments modulo 2^ADDR_W (0x1FFFFF wraps to 0x000000).
- If avr_addr_ld and an increment occur in the same cycle, the load wins. This case is unreachable by the rule above, but it is defined.
- An access that has started is never aborted by snes_mode. The mode change takes effect at the next IDLE.

## Timing
- Reset values: state IDLE, counter 0, avr_rdata 0, avr_ack 0, avr_busy 0, ce_n/oe_n/we_n = 1, dout_en 0, sram_dout 0, sram_addr 0, snes_data all ones.
- Reset mid-access forces IDLE on the next edge. That write may be lost.
- Write latency: acceptance edge to avr_ack = STROBE_CYCLES + 2 cycles.
- Read latency: acceptance edge to avr_ack = STROBE_CYCLES + 1 cycles.
- avr_rdata is valid in the same cycle as avr_ack.
- Back-to-back accesses: with avr_req held high, the next request is accepted in the IDLE cycle after ack. Minimum gap is one IDLE cycle.
- Ownership change: at least one cycle with all strobes high between AVR and SNES control (IDLE → SNES, TURN → IDLE).
- dout_en is never 1 in the same cycle as oe_n = 0.

## Structure
- Shared package `sram_pkg`:
  - state enum;
  - ADDR_W and DATA_W defaults;
  - strobe-idle constant (ce/oe/we = 3'b111).
- Sub-module `sram_addr_counter`: load, increment and wrap, with ADDR_W parameter.
- The FSM, strobe counter and muxes live in `sram_arbiter`.

## Test plan
- Reset, then write: avr_addr_ld with 0x000010, then write 0xA5 with auto_inc, STROBE_CYCLES = 2 → we_n low for exactly 2 cycles, ack at cycle 4, cur_addr = 0x000011.
- Read back: load 0x000010, then read → avr_rdata = 0xA5 with ack at cycle 3; oe_n low for 3 cycles; dout_en stays 0.
- Wrap: load 0x1FFFFF, write with auto_inc → cur_addr = 0x000000.
- Simultaneous events: in IDLE, assert snes_mode and avr_req in the same cycle → SNES state, no ack. Drop snes_mode → TURN, then IDLE, then the request is served; ack arrives 2 + latency cycles after the drop.
- Mode change mid-write: assert snes_mode during W_STROBE → write completes with ack, then one IDLE cycle, then SNES. With snes_addr = 0x000010, snes_data = 0xA5 combinationally.
- Synchronous reset during R_STROBE → next cycle IDLE, all strobes high, no ack, avr_rdata keeps its previous value 0xA5 (avr_rdata is reset to 0 only if reset is held).
